// File: rtl/neo_lb_mixer.sv
// neo_lb_mixer: rotating sprite line buffers with clear-after-read, fix-layer/blank mixing and CPU palette override.
module neo_lb_mixer #(
  parameter int XW = 9,
  parameter int PALW = 8,
  parameter int COLW = 4,
  parameter int NBUF = 2,
  localparam int W = PALW + COLW,
  localparam int BW = $clog2(NBUF)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WR_LD,
  input  logic [XW-1:0]   WR_X,
  input  logic            WR_FLIP,
  input  logic            CE_WR,
  input  logic [PALW-1:0] WR_PAL,
  input  logic [COLW-1:0] WR_COL,
  input  logic            SWAP,
  input  logic            RD_LD,
  input  logic [XW-1:0]   RD_X,
  input  logic            CE_RD,
  input  logic [COLW-1:0] FIX_COL,
  input  logic [3:0]      FIX_PAL,
  input  logic            EN_FIX,
  input  logic            BLANK,
  input  logic            CPU_SEL,
  input  logic [W-1:0]    CPU_ADDR,
  output logic [W-1:0]    PA,
  output logic            PA_VALID,
  output logic [BW-1:0]   WR_BANK,
  output logic [BW-1:0]   RD_BANK,
  output logic            BUSY
);
  if (NBUF < 2) begin : g_bad_nbuf
    $error("neo_lb_mixer: NBUF must be >= 2");
  end
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [W-1:0] mem [NBUF][2**XW];
  logic [XW-1:0] k, wptr, rptr, raddr;
  logic [W-1:0] rd_q, pa_video;
  logic [COLW-1:0] fc;
  logic [3:0] fp;
  logic run, wr_en, rd_en, v1, ef, bl;
  assign run = state == RUN;
  assign BUSY = ~run;
  assign RD_BANK = (WR_BANK == '0) ? BW'(NBUF - 1) : WR_BANK - 1'b1;
  assign raddr = RD_LD ? RD_X : rptr;
  assign wr_en = run & CE_WR & ~WR_LD & (WR_COL != '0);
  assign rd_en = run & CE_RD;
  assign PA = CPU_SEL ? CPU_ADDR : pa_video;
  always_comb state_nx = (state == INIT && k == '1) ? RUN : state;
  always_ff @(posedge CLK)
    if (RST) state <= INIT;
    else state <= state_nx;
  // Write and clear always target different banks, so each bank needs only one write port.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < NBUF; b++)
      if (!run) mem[b][k] <= '0;
      else if (wr_en && WR_BANK == BW'(b)) mem[b][wptr] <= {WR_PAL, WR_COL};
      else if (rd_en && RD_BANK == BW'(b)) mem[b][raddr] <= '0;
    rd_q <= mem[RD_BANK][raddr];
    if (rd_en) {bl, ef, fc, fp} <= {BLANK, EN_FIX, FIX_COL, FIX_PAL};
  end
  always_ff @(posedge CLK)
    if (RST) begin
      WR_BANK <= '0;
      wptr <= '0;
      rptr <= '0;
      k <= '0;
      v1 <= 1'b0;
      pa_video <= '0;
      PA_VALID <= 1'b0;
    end else begin
      k <= run ? '0 : k + 1'b1;
      if (run && SWAP) WR_BANK <= (WR_BANK == BW'(NBUF - 1)) ? '0 : WR_BANK + 1'b1;
      if (run && WR_LD) wptr <= WR_X;
      else if (run && CE_WR) wptr <= WR_FLIP ? wptr - 1'b1 : wptr + 1'b1;
      if (run && (RD_LD || CE_RD)) rptr <= raddr + XW'(CE_RD);
      v1 <= rd_en;
      PA_VALID <= v1;
      if (v1) pa_video <= bl ? '0 : (ef && fc != '0) ? {{(PALW-4){1'b0}}, fp, fc} : rd_q;
    end
endmodule

// File: tb/tb_neo_lb_mixer.sv
// tb_neo_lb_mixer: directed checks of sweep, write/read, flip/wrap, mix priority, swap timing and NBUF=3 rotation.
module tb_neo_lb_mixer;
  logic clk = 0;
  logic rst, wr_ld, wr_flip, ce_wr, swap, rd_ld, ce_rd, en_fix, blank, cpu_sel;
  logic [8:0] wr_x, rd_x;
  logic [7:0] wr_pal;
  logic [3:0] wr_col, fix_col, fix_pal;
  logic [11:0] cpu_addr, pa;
  logic pv, busy;
  logic [0:0] wb, rb;
  logic rst2, swap2, z1;
  logic [3:0] zx, z4;
  logic [7:0] z8;
  logic [11:0] z12, pa2;
  logic pv2, busy2;
  logic [1:0] wb2, rb2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  neo_lb_mixer u_dut (
    .CLK(clk), .RST(rst), .WR_LD(wr_ld), .WR_X(wr_x), .WR_FLIP(wr_flip), .CE_WR(ce_wr),
    .WR_PAL(wr_pal), .WR_COL(wr_col), .SWAP(swap), .RD_LD(rd_ld), .RD_X(rd_x), .CE_RD(ce_rd),
    .FIX_COL(fix_col), .FIX_PAL(fix_pal), .EN_FIX(en_fix), .BLANK(blank), .CPU_SEL(cpu_sel),
    .CPU_ADDR(cpu_addr), .PA(pa), .PA_VALID(pv), .WR_BANK(wb), .RD_BANK(rb), .BUSY(busy)
  );
  neo_lb_mixer #(.XW(4), .NBUF(3)) u_dut3 (
    .CLK(clk), .RST(rst2), .WR_LD(z1), .WR_X(zx), .WR_FLIP(z1), .CE_WR(z1),
    .WR_PAL(z8), .WR_COL(z4), .SWAP(swap2), .RD_LD(z1), .RD_X(zx), .CE_RD(z1),
    .FIX_COL(z4), .FIX_PAL(z4), .EN_FIX(z1), .BLANK(z1), .CPU_SEL(z1),
    .CPU_ADDR(z12), .PA(pa2), .PA_VALID(pv2), .WR_BANK(wb2), .RD_BANK(rb2), .BUSY(busy2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sweep(input string tag, input int expn, input bit second);
    int n = 0, nv = 0;
    while (((second ? busy2 : busy) === 1'b1) && n < 2000) begin
      if ((second ? pv2 : pv) !== 1'b0) nv++;
      n++;
      tick;
    end
    chk({tag, "_len"}, n, expn);
    chk({tag, "_novalid"}, nv, 0);
  endtask
  task automatic wld(input logic [8:0] x, input logic f);
    wr_ld = 1; wr_x = x; wr_flip = f;
    tick;
    wr_ld = 0;
  endtask
  task automatic wpix(input logic [7:0] p, input logic [3:0] c);
    ce_wr = 1; wr_pal = p; wr_col = c;
    tick;
    ce_wr = 0;
  endtask
  task automatic swp;
    swap = 1;
    tick;
    swap = 0;
  endtask
  task automatic rd4(input string tag, input logic [8:0] x, input logic [11:0] e0, e1, e2, e3,
                     input logic [3:0] en, input logic [3:0] bk);
    logic [11:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        rd_ld = (i == 0); rd_x = x; ce_rd = 1; en_fix = en[i]; blank = bk[i];
      end else begin
        ce_rd = 0; en_fix = 0; blank = 0;
      end
      tick;
      if (i > 0) begin
        chk($sformatf("%s_pa%0d", tag, i - 1), pa, e[i-1]);
        chk($sformatf("%s_valid%0d", tag, i - 1), pv, 1);
      end
    end
    tick;
    chk({tag, "_valid_off"}, pv, 0);
    chk({tag, "_hold"}, pa, e3);
  endtask
  initial begin
    rst = 1; wr_ld = 0; wr_x = 0; wr_flip = 0; ce_wr = 0; wr_pal = 0; wr_col = 0; swap = 0;
    rd_ld = 0; rd_x = 0; ce_rd = 1; fix_col = 3; fix_pal = 2; en_fix = 0; blank = 0;
    cpu_sel = 0; cpu_addr = 0;
    rst2 = 1; swap2 = 0; z1 = 0; zx = 0; z4 = 0; z8 = 0; z12 = 0;
    tick;
    chk("rst_busy", busy, 1);
    chk("rst_wbank", wb, 0);
    chk("rst_rbank", rb, 1);
    chk("rst_pa", pa, 0);
    chk("rst_valid", pv, 0);
    rst = 0;
    sweep("sweep", 512, 0);
    tick;
    tick;
    chk("run_valid", pv, 1);
    chk("run_pa0", pa, 0);
    tick;
    chk("run_pa1", pa, 0);
    ce_rd = 0;
    tick;
    tick;
    chk("run_valid_off", pv, 0);
    wld(10, 0);
    wpix(8'h21, 1); wpix(8'h21, 0); wpix(8'h21, 3); wpix(8'h21, 4);
    swp;
    chk("swap_wbank", wb, 1);
    chk("swap_rbank", rb, 0);
    rd4("wsr", 10, 12'h211, 12'h000, 12'h213, 12'h214, 4'b0, 4'b0);
    swp; swp;
    chk("swap2_wbank", wb, 1);
    rd4("cleared", 10, 12'h000, 12'h000, 12'h000, 12'h000, 4'b0, 4'b0);
    wld(1, 1);
    wpix(8'h02, 5); wpix(8'h02, 5); wpix(8'h02, 5);
    swp;
    rd4("flip", 511, 12'h025, 12'h025, 12'h025, 12'h000, 4'b0, 4'b0);
    wld(511, 0);
    wpix(8'h03, 6); wpix(8'h03, 6);
    swp;
    rd4("wrap", 510, 12'h000, 12'h036, 12'h036, 12'h000, 4'b0, 4'b0);
    wld(20, 0);
    wpix(8'h7A, 5); wpix(8'h7A, 5); wpix(8'h7A, 5);
    swp;
    rd4("prio", 20, 12'h023, 12'h7A5, 12'h000, 12'h023, 4'b1001, 4'b0100);
    cpu_sel = 1; cpu_addr = 12'h5C3;
    #1;
    chk("cpu_pa", pa, 12'h5C3);
    cpu_sel = 0;
    #1;
    chk("cpu_release", pa, 12'h023);
    wld(40, 0);
    wpix(8'h15, 5);
    swp;
    wld(40, 0);
    wpix(8'h2A, 4'hA);
    rd_ld = 1; rd_x = 40; ce_rd = 1; swap = 1;
    tick;
    rd_ld = 0; ce_rd = 0; swap = 0;
    chk("swaprd_wbank", wb, 0);
    chk("swaprd_rbank", rb, 1);
    tick;
    chk("swaprd_pa", pa, 12'h155);
    chk("swaprd_valid", pv, 1);
    ce_rd = 1;
    tick;
    rst = 1;
    tick;
    chk("midline_valid", pv, 0);
    chk("midline_pa", pa, 0);
    chk("midline_busy", busy, 1);
    chk("midline_wbank", wb, 0);
    rst = 0;
    repeat (100) tick;
    chk("k100_busy", busy, 1);
    rst = 1;
    tick;
    rst = 0;
    sweep("resweep", 512, 0);
    ce_rd = 0;
    rst2 = 0;
    chk("p3_wbank0", wb2, 0);
    chk("p3_rbank0", rb2, 2);
    sweep("p3_sweep", 16, 1);
    for (int i = 1; i <= 3; i++) begin
      swap2 = 1;
      tick;
      swap2 = 0;
      chk($sformatf("p3_wbank%0d", i), wb2, i % 3);
      chk($sformatf("p3_rbank%0d", i), rb2, i - 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neo_lb_mixer.md
NEO_LB_MIXER -- requirements
Module: neo_lb_mixer

Interface
REQ-001 SHALL have parameter XW, default 9, meaning line-buffer address width; each bank is 2^XW entries deep.
REQ-002 SHALL have parameter PALW, default 8, meaning sprite palette-number width.
REQ-003 SHALL have parameter COLW, default 4, meaning pixel colour-index width; entry and PA width W = PALW+COLW.
REQ-004 SHALL have parameter NBUF, default 2, meaning number of rotating line-buffer banks; NBUF >= 2, elaboration error otherwise.
REQ-005 SHALL have ports, each listed as name, direction, width, meaning:
- CLK  in  1  single clock for all logic and bank RAMs
- RST  in  1  synchronous, active-high reset
- WR_LD  in  1  load write pointer from WR_X
- WR_X  in  XW  write start X
- WR_FLIP  in  1  0 = pointer increments, 1 = pointer decrements
- CE_WR  in  1  write-pixel strobe
- WR_PAL  in  PALW  sprite palette number
- WR_COL  in  COLW  sprite pixel colour
- SWAP  in  1  line boundary; rotates the banks
- RD_LD  in  1  load read pointer from RD_X
- RD_X  in  XW  read start X
- CE_RD  in  1  read-pixel strobe
- FIX_COL  in  COLW  fix pixel colour
- FIX_PAL  in  4  fix palette number
- EN_FIX  in  1  fix layer enable
- BLANK  in  1  forces the output to zero
- CPU_SEL  in  1  CPU palette access active
- CPU_ADDR  in  W  CPU palette address
- PA  out  W  palette address
- PA_VALID  out  1  one-cycle pulse when the video PA updates
- WR_BANK  out  clog2(NBUF)  current write bank
- RD_BANK  out  clog2(NBUF)  current read bank
- BUSY  out  1  initial clear sweep in progress

Function
REQ-006 SHALL implement an FSM with two states, INIT and RUN.
- INIT: an address counter k = 0..2^XW-1 writes 0 to entry k of every bank, one entry per CLK.
- After k = 2^XW-1 the FSM goes to RUN; default sweep length is 512 cycles.
- BUSY = 1 in INIT only.
- In INIT, CE_WR, CE_RD, WR_LD, RD_LD and SWAP are ignored.
REQ-007 Bank indices:
- RD_BANK = (WR_BANK + NBUF - 1) mod NBUF.
- SWAP in RUN sets WR_BANK <= (WR_BANK + 1) mod NBUF.
- The new banks take effect the cycle after SWAP; any same-cycle access uses the old banks.
REQ-008 WR_LD sets wptr <= WR_X; if CE_WR is asserted in the same cycle, that pixel is dropped.
REQ-009 CE_WR without WR_LD:
- If WR_COL != 0, write {WR_PAL, WR_COL} to WR_BANK[wptr].
- If WR_COL == 0 (transparent), skip the write.
- In both cases wptr advances by +1 (WR_FLIP = 0) or -1 (WR_FLIP = 1), modulo 2^XW.
REQ-010 RD_LD sets rptr <= RD_X; if CE_RD is asserted in the same cycle, the read uses RD_X and rptr becomes RD_X+1.
REQ-011 CE_RD at cycle t:
- Read RD_BANK[rptr] into a register at t+1.
- Write 0 to the same entry at t (clear-after-read).
- rptr <= rptr + 1 modulo 2^XW.
REQ-012 At t, CE_RD SHALL also sample FIX_COL, FIX_PAL, EN_FIX and BLANK into a delay stage aligned with the RAM read.
REQ-013 Mix priority, registered into PA_VIDEO at t+2:
- Sampled BLANK = 1 -> 0.
- Otherwise, fix opaque (FIX_COL != 0 and EN_FIX = 1) -> {zeros, FIX_PAL, FIX_COL}.
- Otherwise -> the line-buffer entry.
REQ-014 PA_VALID SHALL be 1 for exactly the cycle after PA_VIDEO loads; PA_VIDEO holds between CE_RD strobes.
REQ-015 PA = CPU_SEL ? CPU_ADDR : PA_VIDEO; this mux is combinational and not delayed, and has no effect on the pipeline.
REQ-016 Consecutive CE_RD strobes SHALL sustain one pixel per CLK.
REQ-017 A SWAP arriving while a read is in flight SHALL NOT corrupt it; the read data comes from the old read bank.

Reset
REQ-018 RST = 1 SHALL set:
- WR_BANK = 0; wptr = rptr = 0.
- PA_VIDEO = 0; PA_VALID = 0; pipeline valid flags = 0.
- k = 0; state = INIT; BUSY = 1 from the next cycle.
REQ-019 RST asserted mid-sweep or mid-line SHALL restart the sweep at k = 0; in-flight reads are discarded and PA_VALID stays 0.
REQ-020 Bank contents are defined only after the sweep completes.

Verification
REQ-021 Reset, default parameters:
- Stimulus: pulse RST; after that, hold CE_RD = 1 and RD_X = 0 from the start.
- Response: BUSY = 1 for 512 cycles; no PA_VALID during the sweep; after RUN, every PA read = 0x000.
REQ-022 Write, swap, read:
- Stimulus: WR_LD with X = 10; 4 pixels COL 1,0,3,4 with PAL 0x21; SWAP; RD_X = 10; 4 × CE_RD.
- Response: PA = 0x211, 0x000, 0x213, 0x214, starting 2 cycles after the first CE_RD.
- Stimulus: re-read the same entries after the next two swaps.
- Response: all 0x000, confirming clear-after-read.
REQ-023 Flip and wrap:
- Stimulus: WR_FLIP = 1, WR_X = 1, 3 pixels COL 5 with PAL 0x02.
- Response: entries 1, 0 and 511 hold 0x025.
- Stimulus: WR_FLIP = 0, WR_X = 511, 2 pixels.
- Response: entries 511 and 0 are written.
REQ-024 Priority, with the LB entry = 0x7A5:
- FIX_COL = 3, FIX_PAL = 2, EN_FIX = 1 -> PA 0x023.
- Same, with EN_FIX = 0 -> PA 0x7A5.
- BLANK = 1 -> PA 0x000.
- CPU_SEL = 1, CPU_ADDR = 0x5C3 -> PA = 0x5C3 in the same cycle.
REQ-025 Parametrisation, with NBUF = 3 and XW = 4:
- Stimulus: 3 SWAPs.
- Response: WR_BANK sequence 1, 2, 0; RD_BANK sequence 0, 1, 2; the sweep lasts 16 cycles.
REQ-026 SWAP and CE_RD in the same cycle SHALL return old-bank data; RST asserted at sweep k = 100 SHALL restart the sweep, giving 512 more BUSY cycles.
